// File: rtl/aer_rx_decoder.sv
// AER link receiver: synchronises req, latches the bundled channel/polarity lines,
// presents each legal event on a valid/ready stream, then completes the 4-phase
// Req/Ack handshake. Keeps saturating event and protocol-error counts.
module aer_rx_decoder #(
  parameter int unsigned NCh        = 2,
  parameter int unsigned SyncStages = 2,
  parameter int unsigned Timeout    = 255,
  parameter int unsigned CntW       = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_i,
  input  logic [NCh-1:0]  ch_i,
  input  logic            up_i,
  output logic            ack_o,
  output logic            ev_valid_o,
  input  logic            ev_ready_i,
  output logic [NCh-1:0]  ev_ch_o,
  output logic            ev_up_o,
  output logic [CntW-1:0] ev_count_o,
  output logic [7:0]      err_count_o,
  output logic            err_pulse_o
);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StLatch   = 3'd1;
  localparam logic [2:0] StCheck   = 3'd2;
  localparam logic [2:0] StPresent = 3'd3;
  localparam logic [2:0] StAck     = 3'd4;
  localparam logic [2:0] StWaitLow = 3'd5;

  // Last timer value allowed in ACK before the request is declared stuck.
  localparam logic [15:0] TimerLast = 16'(Timeout - 1);

  logic [SyncStages-1:0] sync_q;
  logic                  req_s;

  logic [2:0]      state_q, state_d;
  logic [15:0]     timer_q, timer_d;
  logic [NCh-1:0]  hold_ch_q, hold_ch_d;
  logic            hold_up_q, hold_up_d;
  logic [NCh-1:0]  ev_ch_q, ev_ch_d;
  logic            ev_up_q, ev_up_d;
  logic            ack_q, ack_d;
  logic            ev_valid_q, ev_valid_d;
  logic            err_pulse_q, err_pulse_d;
  logic [CntW-1:0] ev_count_q, ev_count_d;
  logic [7:0]      err_count_q, err_count_d;
  logic            hold_onehot;
  logic            err_inc;
  logic            ev_inc;

  assign req_s = sync_q[SyncStages-1];

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  assign hold_onehot = (hold_ch_q != '0) && ((hold_ch_q & (hold_ch_q - NCh'(1))) == '0);

  // Request synchroniser shift chain.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SyncStages-2:0], req_i};
    end
  end

  // Handshake sequencing, event capture and registered output next-state.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    hold_ch_d  = hold_ch_q;
    hold_up_d  = hold_up_q;
    ev_ch_d    = ev_ch_q;
    ev_up_d    = ev_up_q;
    ack_d      = 1'b0;
    ev_valid_d = 1'b0;
    err_inc    = 1'b0;
    ev_inc     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req_s) begin
          state_d = StLatch;
        end
      end
      StLatch: begin
        // Bundled data is stable by the time the synchronised req arrives.
        hold_ch_d = ch_i;
        hold_up_d = up_i;
        state_d   = StCheck;
      end
      StCheck: begin
        if (hold_onehot) begin
          state_d    = StPresent;
          ev_valid_d = 1'b1;
          ev_ch_d    = hold_ch_q;
          ev_up_d    = hold_up_q;
        end else begin
          // Drop the illegal address but still acknowledge the sender.
          err_inc = 1'b1;
          state_d = StAck;
          ack_d   = 1'b1;
          timer_d = '0;
        end
      end
      StPresent: begin
        if (ev_valid_q && ev_ready_i) begin
          ev_inc  = 1'b1;
          state_d = StAck;
          ack_d   = 1'b1;
          timer_d = '0;
        end else begin
          ev_valid_d = 1'b1;
        end
      end
      StAck: begin
        if (!req_s) begin
          state_d = StIdle;
        end else if (timer_q == TimerLast) begin
          err_inc = 1'b1;
          state_d = StWaitLow;
        end else begin
          timer_d = timer_q + 16'd1;
          ack_d   = 1'b1;
        end
      end
      StWaitLow: begin
        // A stuck request must fall before another event can start.
        if (!req_s) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    err_pulse_d = err_inc;

    ev_count_d = ev_count_q;
    if (ev_inc && (ev_count_q != '1)) begin
      ev_count_d = ev_count_q + CntW'(1);
    end

    err_count_d = err_count_q;
    if (err_inc && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end
  end

  // State, holding registers, registered outputs and counters.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      timer_q     <= '0;
      hold_ch_q   <= '0;
      hold_up_q   <= 1'b0;
      ev_ch_q     <= '0;
      ev_up_q     <= 1'b0;
      ack_q       <= 1'b0;
      ev_valid_q  <= 1'b0;
      err_pulse_q <= 1'b0;
      ev_count_q  <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      hold_ch_q   <= hold_ch_d;
      hold_up_q   <= hold_up_d;
      ev_ch_q     <= ev_ch_d;
      ev_up_q     <= ev_up_d;
      ack_q       <= ack_d;
      ev_valid_q  <= ev_valid_d;
      err_pulse_q <= err_pulse_d;
      ev_count_q  <= ev_count_d;
      err_count_q <= err_count_d;
    end
  end

  assign ack_o       = ack_q;
  assign ev_valid_o  = ev_valid_q;
  assign ev_ch_o     = ev_ch_q;
  assign ev_up_o     = ev_up_q;
  assign ev_count_o  = ev_count_q;
  assign err_count_o = err_count_q;
  assign err_pulse_o = err_pulse_q;

endmodule

// File: tb/tb_aer_rx_decoder.sv
// Bench for aer_rx_decoder: directed scenarios with literal expectations plus a
// randomized sender, all checked every cycle against a transaction-level model.
module tb_aer_rx_decoder;

  localparam int SYNC = 2;
  localparam int TO   = 8;
  localparam int CW   = 4;
  localparam int EV_MAX = (1 << CW) - 1;

  localparam int PhIdle    = 0;
  localparam int PhCapture = 1;
  localparam int PhJudge   = 2;
  localparam int PhPresent = 3;
  localparam int PhAck     = 4;
  localparam int PhStuck   = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req;
  logic [1:0]    ch;
  logic          up;
  logic          ready_dir;
  logic          ready_rnd = 1'b0;
  logic          rand_mode;
  logic          ev_ready;
  logic          ack;
  logic          ev_valid;
  logic [1:0]    ev_ch;
  logic          ev_up;
  logic [CW-1:0] ev_count;
  logic [7:0]    err_count;
  logic          err_pulse;

  int checks = 0;
  int passes = 0;
  logic cmp_en = 1'b0;

  assign ev_ready = rand_mode ? ready_rnd : ready_dir;

  aer_rx_decoder #(
    .NCh       (2),
    .SyncStages(SYNC),
    .Timeout   (TO),
    .CntW      (CW)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .req_i      (req),
    .ch_i       (ch),
    .up_i       (up),
    .ack_o      (ack),
    .ev_valid_o (ev_valid),
    .ev_ready_i (ev_ready),
    .ev_ch_o    (ev_ch),
    .ev_up_o    (ev_up),
    .ev_count_o (ev_count),
    .err_count_o(err_count),
    .err_pulse_o(err_pulse)
  );

  always #5 clk = ~clk;

  always @(negedge clk) ready_rnd = 1'($urandom_range(0, 1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  bit         mq[$];
  int         m_phase = PhIdle;
  int         m_age = 0;
  int         m_events = 0;
  int         m_errors = 0;
  logic [1:0] m_hold_ch = '0;
  logic       m_hold_up = 1'b0;
  logic [1:0] m_ev_ch = '0;
  logic       m_ev_up = 1'b0;
  logic       m_ack = 1'b0;
  logic       m_valid = 1'b0;
  logic       m_errp = 1'b0;

  always @(posedge clk) begin : model
    bit rs;
    if (!rst_n) begin
      mq.delete();
      for (int i = 0; i < SYNC; i++) mq.push_back(1'b0);
      m_phase = PhIdle; m_age = 0; m_events = 0; m_errors = 0;
      m_hold_ch = '0; m_hold_up = 1'b0; m_ev_ch = '0; m_ev_up = 1'b0;
      m_ack = 1'b0; m_valid = 1'b0; m_errp = 1'b0;
    end else begin
      // Delay line: req as seen SYNC clocks later.
      mq.push_back(req);
      rs = mq.pop_front();
      m_errp = 1'b0;
      case (m_phase)
        PhIdle:    if (rs) m_phase = PhCapture;
        PhCapture: begin m_hold_ch = ch; m_hold_up = up; m_phase = PhJudge; end
        PhJudge: begin
          if ($countones(m_hold_ch) == 1) begin
            m_phase = PhPresent; m_ev_ch = m_hold_ch; m_ev_up = m_hold_up;
          end else begin
            m_errors++; m_errp = 1'b1; m_phase = PhAck; m_age = 0;
          end
        end
        PhPresent: if (ev_ready) begin m_events++; m_phase = PhAck; m_age = 0; end
        PhAck: begin
          if (!rs) m_phase = PhIdle;
          else begin
            m_age++;
            if (m_age == TO) begin m_phase = PhStuck; m_errors++; m_errp = 1'b1; end
          end
        end
        PhStuck: if (!rs) m_phase = PhIdle;
        default: m_phase = PhIdle;
      endcase
      m_ack   = (m_phase == PhAck);
      m_valid = (m_phase == PhPresent);
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_ack", ack, m_ack);
      chk("m_ev_valid", ev_valid, m_valid);
      chk("m_err_pulse", err_pulse, m_errp);
      chk("m_ev_ch", ev_ch, m_ev_ch);
      chk("m_ev_up", ev_up, m_ev_up);
      chk("m_ev_count", ev_count, (m_events > EV_MAX) ? EV_MAX : m_events);
      chk("m_err_count", err_count, (m_errors > 255) ? 255 : m_errors);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ack(input logic v, input int max, input string name);
    int n = 0;
    while (ack !== v && n < max) begin @(negedge clk); n++; end
    chk(name, ack, v);
  endtask

  task automatic wait_valid(input int max, input string name);
    int n = 0;
    while (ev_valid !== 1'b1 && n < max) begin @(negedge clk); n++; end
    chk(name, ev_valid, 1'b1);
  endtask

  task automatic txn(input logic [1:0] c, input logic u, input int hold);
    ch = c; up = u; req = 1'b1;
    wait_ack(1'b1, 300, "txn_ack_rise");
    step(hold);
    req = 1'b0;
    step(SYNC + 2);
    wait_ack(1'b0, 20, "txn_ack_fall");
    step($urandom_range(1, 4));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    int n, errs, vcnt;
    logic [1:0] c;
    rst_n = 1'b0; req = 1'b0; ch = 2'($urandom); up = 1'($urandom);
    ready_dir = 1'b0; rand_mode = 1'b0; cmp_en = 1'b1;

    // 1: reset state
    step(3);
    chk("rst_ack", ack, 0);
    chk("rst_valid", ev_valid, 0);
    chk("rst_ev_count", ev_count, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_err_pulse", err_pulse, 0);
    rst_n = 1'b1; ch = 2'b10; up = 1'b1; ready_dir = 1'b1;
    step(1);

    // 2: valid Ch2-Up event, latency and ack release
    req = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step(1);
      if (k < 5) chk("t2_valid_early", ev_valid, 0);
    end
    chk("t2_valid_c5", ev_valid, 1);
    chk("t2_ev_ch", ev_ch, 2'b10);
    chk("t2_ev_up", ev_up, 1);
    step(1);
    chk("t2_ack_c6", ack, 1);
    chk("t2_valid_gone", ev_valid, 0);
    req = 1'b0;
    n = 0;
    while (ack === 1'b1 && n < 10) begin step(1); n++; end
    chk("t2_ack_drop_lat", n, SYNC + 1);
    chk("t2_ev_count", ev_count, 1);
    step(2);

    // 3: back-pressure
    ready_dir = 1'b0; ch = 2'b01; up = 1'b0; req = 1'b1;
    wait_valid(20, "t3_valid");
    for (int k = 0; k < 20; k++) begin
      step(1);
      chk("t3_valid_held", ev_valid, 1);
      chk("t3_no_ack", ack, 0);
    end
    ready_dir = 1'b1;
    step(1);
    chk("t3_ack_next", ack, 1);
    chk("t3_ev_ch_hold", ev_ch, 2'b01);
    req = 1'b0;
    step(SYNC + 2);
    chk("t3_ack_low", ack, 0);
    chk("t3_ev_count", ev_count, 2);

    // 4: illegal address
    ch = 2'b11; up = 1'b1; req = 1'b1;
    errs = 0; vcnt = 0;
    for (int k = 0; k < 8; k++) begin
      step(1);
      if (err_pulse === 1'b1) errs++;
      if (ev_valid === 1'b1) vcnt++;
    end
    chk("t4_err_pulses", errs, 1);
    chk("t4_no_valid", vcnt, 0);
    chk("t4_ack_high", ack, 1);
    req = 1'b0;
    step(SYNC + 2);
    chk("t4_ack_low", ack, 0);
    chk("t4_err_count", err_count, 1);
    chk("t4_ev_ch_kept", ev_ch, 2'b01);

    // 5: stuck request
    ch = 2'b01; up = 1'b0; ready_dir = 1'b1; req = 1'b1;
    wait_ack(1'b1, 20, "t5_ack_rise");
    n = 0;
    while (ack === 1'b1 && n < 50) begin step(1); n++; end
    chk("t5_ack_cycles", n, TO);
    chk("t5_err_pulse", err_pulse, 1);
    chk("t5_err_count", err_count, 2);
    for (int k = 0; k < 20; k++) begin
      step(1);
      chk("t5_stuck_no_valid", ev_valid, 0);
      chk("t5_stuck_no_ack", ack, 0);
    end
    req = 1'b0;
    step(SYNC + 2);
    ch = 2'b10; up = 1'b1; req = 1'b1;
    wait_ack(1'b1, 20, "t5_rearm_ack");
    chk("t5_ev_count", ev_count, 4);
    req = 1'b0;
    step(SYNC + 2);
    chk("t5_ack_low", ack, 0);

    // random traffic: any channel pattern, random ready, random req hold
    rand_mode = 1'b1;
    for (int t = 0; t < 40; t++) begin
      txn(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom_range(0, 12));
    end
    rand_mode = 1'b0;

    // 6: saturation
    ready_dir = 1'b1;
    for (int t = 0; t < 17; t++) begin
      c = 2'(1 << $urandom_range(0, 1));
      txn(c, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end
    chk("t6_ev_sat", ev_count, 4'hF);

    // 6: reset while an event is presented
    ready_dir = 1'b0; ch = 2'b10; up = 1'b0; req = 1'b1;
    wait_valid(20, "t6_valid");
    step(3);
    rst_n = 1'b0;
    step(1);
    chk("t6_rst_valid", ev_valid, 0);
    chk("t6_rst_ack", ack, 0);
    chk("t6_rst_ev_count", ev_count, 0);
    chk("t6_rst_err_count", err_count, 0);
    chk("t6_rst_ev_ch", ev_ch, 0);
    rst_n = 1'b1;
    wait_valid(20, "t6_rereq_valid");
    chk("t6_rereq_ch", ev_ch, 2'b10);
    ready_dir = 1'b1;
    step(1);
    chk("t6_rereq_ack", ack, 1);
    chk("t6_rereq_count", ev_count, 1);
    req = 1'b0;
    step(SYNC + 2);
    chk("t6_ack_low", ack, 0);

    step(2);
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
